// File: rtl/lcd1602_bus_writer.sv
// lcd1602_bus_writer: byte-level HD44780 / LCD1602 bus driver.
//
// Runs the power-on wait and the fixed four-command init sequence by itself, then
// accepts (rs, byte) write requests over a valid/ready handshake. Each write is
// sequenced as setup (E low), enable pulse (E high) and hold (E low). It is
// followed by a wait for the controller's execution time before the next write.
//
// Ports:
//   clock_in   system clock
//   reset_in   asynchronous reset, active-high; restarts the full power-up sequence
//   in_valid   write request present
//   in_ready   request accepted on this cycle's edge if in_valid (IDLE after init only)
//   in_rs      0 = instruction, 1 = data
//   in_data    byte to write
//   init_done  power-up init complete; sticky until reset
//   busy       high whenever the writer is not idle
//   lcd_data   LCD DB[7:0]
//   lcd_e      LCD enable
//   lcd_rw     LCD R/W, always 0 (write only)
//   lcd_rs     LCD register select
module lcd1602_bus_writer #(
  parameter int unsigned T_POWERUP    = 750000,
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_PULSE      = 12,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_EXEC_SHORT = 1850,
  parameter int unsigned T_EXEC_LONG  = 76000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs
);

  typedef enum logic [2:0] {
    StPowerup,
    StLoad,
    StSetup,
    StPulse,
    StHold,
    StWait,
    StIdle
  } state_e;

  // The counter is loaded with N-1 on entry to a timed state and the state is left
  // on the cycle it reads zero, giving exactly N cycles in that state.
  localparam logic [23:0] LdSetup     = 24'(T_SETUP - 1);
  localparam logic [23:0] LdPulse     = 24'(T_PULSE - 1);
  localparam logic [23:0] LdHold      = 24'(T_HOLD - 1);
  localparam logic [23:0] LdExecShort = 24'(T_EXEC_SHORT - 1);
  localparam logic [23:0] LdExecLong  = 24'(T_EXEC_LONG - 1);

  // Reset leaves the counter at zero, so the first power-up cycle only arms the
  // counter with the remaining N-2; that first cycle counts as one of the N.
  localparam int unsigned PowerupArm    = (T_POWERUP > 1) ? T_POWERUP - 2 : 0;
  localparam logic [23:0] LdPowerup     = 24'(PowerupArm);
  localparam bit          PowerupSingle = (T_POWERUP <= 1);

  state_e      r_state;
  logic [23:0] r_cnt;
  logic        r_armed;
  logic [1:0]  r_idx;
  logic        r_init_done;
  logic        r_rs;
  logic [7:0]  r_byte;

  state_e      w_state_d;
  logic [23:0] w_cnt_d;
  logic        w_armed_d;
  logic [1:0]  w_idx_d;
  logic        w_init_done_d;
  logic        w_rs_d;
  logic [7:0]  w_byte_d;

  logic        w_cnt_zero;
  logic        w_long;
  logic        w_ready;
  logic [7:0]  w_rom_byte;

  // Fixed init sequence: 8-bit/2-line/5x8, display on, entry increment, clear.
  always_comb begin
    w_rom_byte = 8'h38;
    unique case (r_idx)
      2'd0: w_rom_byte = 8'h38;
      2'd1: w_rom_byte = 8'h0C;
      2'd2: w_rom_byte = 8'h06;
      2'd3: w_rom_byte = 8'h01;
      default: w_rom_byte = 8'h38;
    endcase
  end

  assign w_cnt_zero = (r_cnt == 24'd0);
  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  assign w_long     = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));
  assign w_ready    = (r_state == StIdle) && r_init_done;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= StPowerup;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_idx       <= '0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_byte      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_armed     <= w_armed_d;
      r_idx       <= w_idx_d;
      r_init_done <= w_init_done_d;
      r_rs        <= w_rs_d;
      r_byte      <= w_byte_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = w_cnt_zero ? r_cnt : r_cnt - 24'd1;
    w_armed_d     = r_armed;
    w_idx_d       = r_idx;
    w_init_done_d = r_init_done;
    w_rs_d        = r_rs;
    w_byte_d      = r_byte;

    unique case (r_state)
      StPowerup: begin
        if (!r_armed) begin
          w_armed_d = 1'b1;
          if (PowerupSingle) begin
            w_state_d = StLoad;
          end else begin
            w_cnt_d = LdPowerup;
          end
        end else if (w_cnt_zero) begin
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_rs_d    = 1'b0;
        w_byte_d  = w_rom_byte;
        w_cnt_d   = LdSetup;
        w_state_d = StSetup;
      end
      StSetup: begin
        if (w_cnt_zero) begin
          w_cnt_d   = LdPulse;
          w_state_d = StPulse;
        end
      end
      StPulse: begin
        if (w_cnt_zero) begin
          w_cnt_d   = LdHold;
          w_state_d = StHold;
        end
      end
      StHold: begin
        if (w_cnt_zero) begin
          w_cnt_d   = w_long ? LdExecLong : LdExecShort;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (w_cnt_zero) begin
          if (r_init_done) begin
            w_state_d = StIdle;
          end else if (r_idx == 2'd3) begin
            w_init_done_d = 1'b1;
            w_state_d     = StIdle;
          end else begin
            w_idx_d   = r_idx + 2'd1;
            w_state_d = StLoad;
          end
        end
      end
      StIdle: begin
        if (in_valid && w_ready) begin
          w_rs_d    = in_rs;
          w_byte_d  = in_data;
          w_cnt_d   = LdSetup;
          w_state_d = StSetup;
        end
      end
      default: begin
        w_state_d = StPowerup;
      end
    endcase
  end

  // Outputs decode straight from registers, so reset clears lcd_e without a clock.
  assign in_ready  = w_ready;
  assign busy      = (r_state != StIdle);
  assign init_done = r_init_done;
  assign lcd_e     = (r_state == StPulse);
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = r_rs;
  assign lcd_data  = r_byte;

endmodule

// File: tb/tb_lcd1602_bus_writer.sv
module tb_lcd1602_bus_writer;

  localparam int P_PWR = 10;
  localparam int P_S   = 2;
  localparam int P_P   = 3;
  localparam int P_H   = 2;
  localparam int P_ES  = 5;
  localparam int P_EL  = 20;

  logic       clk;
  logic       reset_in;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       init_done;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;

  lcd1602_bus_writer #(
    .T_POWERUP   (P_PWR),
    .T_SETUP     (P_S),
    .T_PULSE     (P_P),
    .T_HOLD      (P_H),
    .T_EXEC_SHORT(P_ES),
    .T_EXEC_LONG (P_EL)
  ) dut (
    .clock_in (clk),
    .reset_in (reset_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .init_done(init_done),
    .busy     (busy),
    .lcd_data (lcd_data),
    .lcd_e    (lcd_e),
    .lcd_rw   (lcd_rw),
    .lcd_rs   (lcd_rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: the writer is described by the start cycle of the current
  // write (first setup cycle) and the first cycle it is free again.
  int         m_t0;
  int         m_free;
  int         m_idx;
  bit         m_init_done;
  logic [8:0] m_cur;
  logic [8:0] m_prev;
  logic [7:0] m_rom [4];

  // Observations of the DUT for the hand-computed timing expectations.
  logic [8:0] rom_lit [4];
  int         rise_q [$];
  logic [8:0] byte_q [$];
  int         pulses;
  int         fall_cyc;
  int         done_cyc;
  bit         prev_e;
  bit         prev_done;
  bit         obs_rdy;
  bit         obs_acc;
  bit         obs_e;
  bit         obs_done;
  logic [8:0] obs_rsd;
  int         obs_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int write_len(input logic rs, input logic [7:0] b);
    int ex;
    ex = (!rs && (b >= 8'd1) && (b <= 8'd3)) ? P_EL : P_ES;
    return P_S + P_P + P_H + ex;
  endfunction

  task automatic model_reset();
    m_t0        = 1 << 30;
    m_free      = P_PWR;
    m_idx       = 0;
    m_init_done = 1'b0;
    m_cur       = '0;
    m_prev      = '0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance model.
  task automatic tick(input logic v, input logic rs, input logic [7:0] d);
    bit         exp_rdy;
    bit         exp_e;
    logic [8:0] exp_rsd;
    in_valid = v;
    in_rs    = rs;
    in_data  = d;
    #1;
    if (!m_init_done && cyc == m_free) begin
      if (m_idx == 4) begin
        m_init_done = 1'b1;
      end else begin
        m_prev = m_cur;
        m_cur  = {1'b0, m_rom[m_idx]};
        m_t0   = cyc + 1;
        m_free = m_t0 + write_len(1'b0, m_rom[m_idx]);
        m_idx++;
      end
    end
    exp_rdy = m_init_done && (cyc >= m_free);
    exp_e   = (cyc >= m_t0 + P_S) && (cyc < m_t0 + P_S + P_P);
    exp_rsd = (cyc >= m_t0) ? m_cur : m_prev;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("busy", int'(busy), int'(!exp_rdy));
    chk("init_done", int'(init_done), int'(m_init_done));
    chk("lcd_e", int'(lcd_e), int'(exp_e));
    chk("lcd_rw", int'(lcd_rw), 0);
    chk("lcd_rs_data", int'({lcd_rs, lcd_data}), int'(exp_rsd));

    if (lcd_e && !prev_e) begin
      pulses++;
      rise_q.push_back(cyc);
      byte_q.push_back({lcd_rs, lcd_data});
    end
    if (!lcd_e && prev_e) fall_cyc = cyc;
    if (init_done && !prev_done) done_cyc = cyc;
    prev_e    = lcd_e;
    prev_done = init_done;
    obs_rdy   = in_ready;
    obs_acc   = in_ready && v;
    obs_e     = lcd_e;
    obs_done  = init_done;
    obs_rsd   = {lcd_rs, lcd_data};
    obs_cyc   = cyc;

    if (exp_rdy && v) begin
      m_prev = m_cur;
      m_cur  = {rs, d};
      m_t0   = cyc + 1;
      m_free = cyc + 1 + write_len(rs, d);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n  = 0;
    rc = -1;
    do begin
      tick(1'b0, 1'b0, 8'h00);
      n++;
    end while (!obs_rdy && n < 200);
    if (!obs_rdy) chk("wait_ready_timeout", 0, 1);
    else rc = obs_cyc;
  endtask

  task automatic run_init(input bit hold_valid);
    int n;
    @(negedge clk);
    reset_in = 1'b0;
    model_reset();
    cyc      = 0;
    pulses   = 0;
    rise_q.delete();
    byte_q.delete();
    fall_cyc  = -1;
    done_cyc  = -1;
    prev_e    = 1'b0;
    prev_done = 1'b0;
    n = 0;
    do begin
      tick(hold_valid, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      n++;
    end while (!obs_done && n < 300);
    chk("init_timeout", int'(obs_done), 1);
    chk("init_pulses", pulses, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < byte_q.size()) chk("init_byte", int'(byte_q[i]), int'(rom_lit[i]));
    end
    if (rise_q.size() > 0) chk("first_rise", rise_q[0], 13);
    chk("done_gap", done_cyc - fall_cyc, 22);
    chk("ready_at_done", int'(obs_rdy), 1);
    chk("accept_at_done", int'(obs_acc), int'(hold_valid));
  endtask

  task automatic single_req(input logic rs, input logic [7:0] d, input int lat, input string nm);
    int a;
    int rc;
    tick(1'b1, rs, d);
    a = obs_cyc;
    chk({nm, "_accept"}, int'(obs_acc), 1);
    tick(1'b0, 1'b0, 8'h00);
    chk({nm, "_rs_data"}, int'(obs_rsd), int'({rs, d}));
    wait_ready(rc);
    chk({nm, "_ready_lat"}, rc - a, lat);
    if (rise_q.size() > 0) chk({nm, "_rise_lat"}, rise_q[$] - a, 3);
  endtask

  initial begin
    int rc;
    int n;
    int a1;
    int a2;
    m_rom[0] = 8'h38; m_rom[1] = 8'h0C; m_rom[2] = 8'h06; m_rom[3] = 8'h01;
    rom_lit[0] = 9'h038; rom_lit[1] = 9'h00C; rom_lit[2] = 9'h006; rom_lit[3] = 9'h001;
    reset_in = 1'b1;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_lcd_rw", int'(lcd_rw), 0);
    chk("rst_lcd_rs_data", int'({lcd_rs, lcd_data}), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);

    run_init(1'b0);

    wait_ready(rc);
    single_req(1'b1, 8'h41, 13, "req41");

    // Back-to-back with in_valid held continuously.
    n = 0;
    do begin tick(1'b1, 1'b0, 8'h80); n++; end while (!obs_acc && n < 50);
    a1 = obs_cyc;
    n = 0;
    do begin tick(1'b1, 1'b1, 8'h42); n++; end while (!obs_acc && n < 50);
    a2 = obs_cyc;
    chk("b2b_accepted", int'(obs_acc), 1);
    chk("b2b_spacing", a2 - a1, 13);
    wait_ready(rc);

    single_req(1'b0, 8'h02, 28, "home");
    single_req(1'b1, 8'h01, 13, "data01");

    // Random traffic, data changing every cycle while valid may be held.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
    end
    wait_ready(rc);

    // Reset while E is high.
    tick(1'b1, 1'b1, 8'h55);
    n = 0;
    do begin tick(1'b0, 1'b0, 8'h00); n++; end while (!obs_e && n < 20);
    chk("pre_reset_e", int'(lcd_e), 1);
    #2;
    reset_in = 1'b1;
    #1;
    chk("mid_rst_lcd_e", int'(lcd_e), 0);
    chk("mid_rst_init_done", int'(init_done), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk);

    // in_valid held from reset release: nothing accepted until init completes.
    run_init(1'b1);
    wait_ready(rc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd1602_bus_writer.md
Name: lcd1602_bus_writer

Overview:
- Byte-level HD44780/LCD1602 bus driver that sits directly downstream of the team's text/command sequencers.
- Accepts (rs, byte) write requests over a valid/ready handshake.
- Generates correctly timed RS/RW/DATA/E waveforms, then waits the controller execution time for each request.
- Owns the power-on wait and the fixed initialisation sequence, so upstream logic only sends content and cursor commands after init_done.

Parameters:
T_POWERUP, 750000, cycles to wait after reset before the first init write (15 ms at 50 MHz)
T_SETUP, 2, cycles RS/DATA are stable with E low before the E rising edge
T_PULSE, 12, cycles E is held high
T_HOLD, 2, cycles RS/DATA are held after the E falling edge
T_EXEC_SHORT, 1850, post-write wait for normal commands and data (37 us)
T_EXEC_LONG, 76000, post-write wait for clear/home commands (1.52 ms)

Ports:
clock_in  input  1  system clock
reset_in  input  1  asynchronous reset, active-high
in_valid  input  1  write request present
in_ready  output 1  writer accepts a request this cycle
in_rs     input  1  0 = instruction, 1 = data
in_data   input  8  byte to write
init_done output 1  power-up init complete; sticky until reset
busy      output 1  high whenever not in IDLE
lcd_data  output 8  LCD DB[7:0]
lcd_e     output 1  LCD enable
lcd_rw    output 1  LCD R/W, tied 0 (write only)
lcd_rs    output 1  LCD register select

Behaviour:
- Reset (async, active-high):
  - state = POWERUP; all counters 0; init index 0.
  - lcd_e = lcd_rw = lcd_rs = 0; lcd_data = 0x00.
  - in_ready = 0, init_done = 0, busy = 1.
  - Reset asserted mid-transfer drops lcd_e immediately and restarts the full power-up sequence.
- States: POWERUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
- POWERUP: count T_POWERUP cycles, then go to LOAD.
- LOAD: latch the init ROM entry at the current index (rs = 0) into the byte register, then go to SETUP. Init ROM order:
  - 0x38 (8-bit, 2-line, 5x8)
  - 0x0C (display on, cursor off)
  - 0x06 (entry increment)
  - 0x01 (clear)
- IDLE:
  - in_ready = 1 only in IDLE with init_done = 1.
  - A transfer occurs on a clock edge where in_valid & in_ready. in_rs and in_data are captured into the byte register on that edge, and the next state is SETUP.
  - in_ready is combinational from state only; it does not depend on in_valid.
- SETUP: lcd_rs / lcd_data driven from the byte register, lcd_e = 0, for T_SETUP cycles.
- PULSE: lcd_e = 1 for exactly T_PULSE cycles.
- HOLD: lcd_e = 0, lcd_rs / lcd_data unchanged, for T_HOLD cycles.
- WAIT:
  - Duration is T_EXEC_LONG if rs = 0 and byte is 0x01, 0x02 or 0x03; otherwise T_EXEC_SHORT.
  - On exit during init: increment index; after index 3 set init_done = 1 and go to IDLE, else go to LOAD.
  - On exit outside init: go to IDLE.
- lcd_rs / lcd_data keep their last value in IDLE. They change only on SETUP entry.
- Latency, measured from the accepting edge k:
  - lcd_e rises at edge k+1+T_SETUP.
  - lcd_e falls at edge k+1+T_SETUP+T_PULSE.
  - in_ready reasserts at edge k+1+T_SETUP+T_PULSE+T_HOLD+T_EXEC.
- Throughput: at most one request per full write cycle. There is no buffering; upstream holds in_valid until accepted.
- Requests presented during POWERUP or init are not accepted and are not lost (in_ready = 0).
- Counters: a single down-counter, 24 bits wide. Every parameter is ≥ 1; a parameter value of N yields exactly N cycles in its state.
- lcd_rw is constant 0.

Test Plan (all timing parameters overridden to T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC_SHORT=5, T_EXEC_LONG=20):
- Reset release, in_valid = 0:
  - Exactly four E pulses, carrying 0x38, 0x0C, 0x06, 0x01 with rs = 0.
  - First E rise 10+1+2 cycles after reset release.
  - Gap after 0x01 is 20 cycles; then init_done = 1 and in_ready = 1.
- After init, single request rs=1, data=0x41:
  - lcd_rs = 1 and lcd_data = 0x41 one cycle after acceptance.
  - E high 3 cycles starting 3 cycles after acceptance.
  - in_ready returns 1+2+3+2+5 = 13 cycles after acceptance.
- Back-to-back requests 0x80 (rs=0) then 0x42 (rs=1), in_valid held continuously:
  - Second request accepted exactly 13 cycles after the first.
  - 0x80 uses the short wait.
- Request rs=0, data=0x02 -> WAIT lasts 20 cycles. Request rs=1, data=0x01 -> WAIT lasts 5 cycles.
- in_valid held high from reset -> not accepted before init_done. Captured byte equals the in_data presented on the accepting edge.
- Reset asserted while lcd_e = 1:
  - lcd_e goes 0 without waiting for a clock.
  - init_done = 0 and busy = 1; after release the full init sequence repeats.
